// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : Single-cycle instruction fetch stage with branch redirect, stall
//            and a sticky fetch-fault on misaligned or out-of-range PCs.
//            Optional macro IFETCH_PREDECODE_EN folds unconditional B targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic        fetch_valid,
    output logic        fault
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_fetch_pc;
    logic [31:0] r_fetch_instr;
    logic        r_fetch_valid;
    logic        r_fault;

    logic [64:0] w_pc_last;
    logic        w_illegal;
    logic [63:0] w_next_pc;

    // One extra bit so a PC near the top of the address space cannot wrap
    // past the range check.
    assign w_pc_last = {1'b0, r_pc} + 65'd3;
    assign w_illegal = (r_pc[1:0] != 2'b00) || (w_pc_last >= 65'(MEM_SIZE));

`ifdef IFETCH_PREDECODE_EN
    always_comb begin
        w_next_pc = r_pc + 64'd4;
        if (imem_instr[31:26] == 6'b000101) begin
            w_next_pc = r_pc + {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00};
        end
    end
`else
    assign w_next_pc = r_pc + 64'd4;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_fetch_pc    <= 64'd0;
            r_fetch_instr <= 32'd0;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (br_taken) begin
                        r_pc          <= br_target;
                        r_fetch_valid <= 1'b0;
                    end else if (w_illegal) begin
                        r_state       <= S_FAULT;
                        r_fault       <= 1'b1;
                        r_fetch_valid <= 1'b0;
                    end else if (!stall) begin
                        r_fetch_pc    <= r_pc;
                        r_fetch_instr <= imem_instr;
                        r_fetch_valid <= 1'b1;
                        r_pc          <= w_next_pc;
                    end
                end
                S_FAULT: begin
                    // Terminal until reset; everything holds.
                    r_fetch_valid <= 1'b0;
                    r_fault       <= 1'b1;
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_instr = r_fetch_instr;
    assign fetch_valid = r_fetch_valid;
    assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch (MEM_SIZE 1024).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] B_INSTR = {6'b000101, 26'h3FF_FFFE};

    inst_fetch #(
        .MEM_SIZE (1024),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_valid (fetch_valid),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        if (a == 64'h20) return B_INSTR;
        return 32'hA000_0000 | a[31:0];
    endfunction

    always_comb imem_instr = rom(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 64'h0;
        #1;
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_pc",    fetch_pc,         64'd0);
        check("rst_instr", 64'(fetch_instr), 64'd0);
        check("rst_fault", 64'(fault),       64'd0);
        check("rst_addr",  imem_addr,        64'd0);
        step();
        step();
        reset = 1'b0;

        // Sequential fetch of 0 and 4
        step();
        check("seq0_pc",    fetch_pc,         64'h0);
        check("seq0_instr", 64'(fetch_instr), 64'hA000_0000);
        check("seq0_valid", 64'(fetch_valid), 64'd1);
        step();
        check("seq1_pc",    fetch_pc,         64'h4);
        check("seq1_instr", 64'(fetch_instr), 64'hA000_0004);
        check("seq1_addr",  imem_addr,        64'h8);

        // Three stalled cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr,        64'h8);
            check("stall_pc",    fetch_pc,         64'h4);
            check("stall_valid", 64'(fetch_valid), 64'd1);
        end
        stall = 1'b0;
        step();
        check("rel_pc",    fetch_pc,         64'h8);
        check("rel_instr", 64'(fetch_instr), 64'hA000_0008);
        step();
        check("seq3_pc",   fetch_pc,         64'hC);
        check("seq3_addr", imem_addr,        64'h10);

        // Branch wins over a simultaneous stall
        br_taken  = 1'b1;
        br_target = 64'h40;
        stall     = 1'b1;
        step();
        br_taken = 1'b0;
        stall    = 1'b0;
        check("br_valid",   64'(fetch_valid), 64'd0);
        check("br_addr",    imem_addr,        64'h40);
        check("br_hold_pc", fetch_pc,         64'hC);
        step();
        check("br_pc",    fetch_pc,         64'h40);
        check("br_valid1", 64'(fetch_valid), 64'd1);
        check("br_instr", 64'(fetch_instr), 64'hA000_0040);

        // Unconditional B with imm26=-2 at 0x20
        br_taken  = 1'b1;
        br_target = 64'h20;
        step();
        br_taken = 1'b0;
        step();
        check("b_pc",    fetch_pc,         64'h20);
        check("b_instr", 64'(fetch_instr), 64'(B_INSTR));
        check("b_valid", 64'(fetch_valid), 64'd1);
`ifdef IFETCH_PREDECODE_EN
        check("b_next",  imem_addr,        64'h18);
`else
        check("b_next",  imem_addr,        64'h24);
`endif

        // Run off the end of memory
        br_taken  = 1'b1;
        br_target = 64'h3F8;
        step();
        br_taken = 1'b0;
        step();
        check("end0_pc", fetch_pc, 64'h3F8);
        step();
        check("end1_pc",    fetch_pc,         64'h3FC);
        check("end1_valid", 64'(fetch_valid), 64'd1);
        check("end1_fault", 64'(fault),       64'd0);
        check("end1_addr",  imem_addr,        64'h400);
        step();
        check("end2_fault", 64'(fault),       64'd1);
        check("end2_valid", 64'(fetch_valid), 64'd0);
        check("end2_pc",    fetch_pc,         64'h3FC);
        check("end2_addr",  imem_addr,        64'h400);

        // Asynchronous reset out of FAULT
        #2;
        reset = 1'b1;
        #1;
        check("arst_fault", 64'(fault),       64'd0);
        check("arst_addr",  imem_addr,        64'h0);
        check("arst_pc",    fetch_pc,         64'h0);
        check("arst_valid", 64'(fetch_valid), 64'd0);
        step();
        reset = 1'b0;

        // Misaligned branch target faults one edge after it is loaded
        br_taken  = 1'b1;
        br_target = 64'h3FE;
        step();
        br_taken = 1'b0;
        check("mis_addr",   imem_addr,  64'h3FE);
        check("mis_fault0", 64'(fault), 64'd0);
        step();
        check("mis_fault1", 64'(fault),       64'd1);
        check("mis_valid",  64'(fetch_valid), 64'd0);

        // Redirects are ignored in FAULT
        br_taken  = 1'b1;
        br_target = 64'h100;
        step();
        step();
        br_taken = 1'b0;
        check("flt_addr",  imem_addr,        64'h3FE);
        check("flt_fault", 64'(fault),       64'd1);
        check("flt_valid", 64'(fetch_valid), 64'd0);

        reset = 1'b1;
        #1;
        check("rst2_fault", 64'(fault), 64'd0);
        check("rst2_addr",  imem_addr,  64'h0);
        step();
        reset = 1'b0;
        step();
        check("post_pc",    fetch_pc,         64'h0);
        check("post_valid", 64'(fetch_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
